// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle, handshaked 64-bit data memory for the pipeline MEM stage.
//   A single load or store is accepted on the request channel. After LATENCY
//   cycles it is committed to the storage array, and its result is presented
//   on the response channel until the requester consumes it. Only one
//   transaction is in flight at a time.
//
// Parameters
//   DEPTH   : number of 64-bit words (power of two, >= 2)
//   LATENCY : cycles from request acceptance to resp_valid (>= 1)
//
// Ports
//   Clk        : clock, rising edge
//   Reset      : synchronous, active-high; aborts any transaction in flight;
//                does not clear the storage array
//   req_valid  : requester has a transaction
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address; word index = req_addr[log2(DEPTH)+2:3]
//   req_wdata  : store data
//   req_ready  : high in IDLE only (decoded from state)
//   resp_valid : response available (RESP state)
//   resp_ready : requester consumes the response
//   resp_rdata : load data; 0 for stores and faulted transactions
//   resp_err   : transaction faulted
//
// Build option
//   DMEM_ERR_CHECK_EN : when defined, misaligned (req_addr[2:0] != 0) or
//                       out-of-range (req_addr >= DEPTH*8) requests fault.
//                       A faulted request performs no write and returns 0.
//                       When undefined, resp_err is 0, the low three address
//                       bits are ignored, and the index wraps modulo DEPTH.

module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    // Transaction latched at acceptance.
    logic            lat_write, lat_write_nxt;
    logic [AW-1:0]   lat_idx, lat_idx_nxt;
    logic [63:0]     lat_wdata, lat_wdata_nxt;
    logic            lat_err, lat_err_nxt;

    // Response registers.
    logic [63:0]     rdata_q, rdata_nxt;
    logic            err_q, err_nxt;

    logic            mem_we;
    logic [AW-1:0]   req_idx;
    logic            req_err;

    // Storage starts at zero and is deliberately not touched by Reset.
    logic [63:0]     mem [DEPTH] = '{default: '0};

    assign req_idx = req_addr[AW+2:3];

`ifdef DMEM_ERR_CHECK_EN
    assign req_err = (req_addr[2:0] != 3'b000) || (req_addr[63:AW+3] != '0);
`else
    logic unused_addr_bits;
    assign req_err          = 1'b0;
    assign unused_addr_bits = ^{req_addr[63:AW+3], req_addr[2:0]};
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_write_nxt = lat_write;
        lat_idx_nxt   = lat_idx;
        lat_wdata_nxt = lat_wdata;
        lat_err_nxt   = lat_err;
        rdata_nxt     = rdata_q;
        err_nxt       = err_q;
        mem_we        = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_write_nxt = req_write;
                    lat_idx_nxt   = req_idx;
                    lat_wdata_nxt = req_wdata;
                    lat_err_nxt   = req_err;
                    cnt_nxt       = CW'(LATENCY - 1);
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    // Commit: a store writes now, so a following load sees it.
                    mem_we    = lat_write & ~lat_err;
                    rdata_nxt = (lat_write | lat_err) ? '0 : mem[lat_idx];
                    err_nxt   = lat_err;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_write <= lat_write_nxt;
            lat_idx   <= lat_idx_nxt;
            lat_wdata <= lat_wdata_nxt;
            lat_err   <= lat_err_nxt;
            rdata_q   <= rdata_nxt;
            err_q     <= err_nxt;
        end
    end

    // Reset wins over a commit on the same edge, so the store is dropped.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
